// File: rtl/adc_uart_logger_if.sv
// Handshake bundle between the frame sequencer, the SPI ADC master and the
// UART transmitter. The sequencer is the master of both request channels.
interface adc_uart_logger_if #(
    parameter int CH_W   = 2,
    parameter int DATA_W = 8
);
    logic              adc_start;
    logic [CH_W-1:0]   adc_ch;
    logic              adc_done;
    logic [DATA_W-1:0] adc_data;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;

    modport master (
        output adc_start, adc_ch, tx_start, tx_data,
        input  adc_done, adc_data, tx_done
    );

    modport slave (
        input  adc_start, adc_ch, tx_start, tx_data,
        output adc_done, adc_data, tx_done
    );
endinterface

// File: rtl/adc_uart_logger.sv
// Multi-channel ADC sampler that renders each trigger as one ASCII-hex text
// frame ("XX,XX,...,XX\r\n") and streams it byte by byte to a UART TX.
module adc_uart_logger #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int DATA_W     = 8,
    parameter int PERIOD_CYC = 50_000_000
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              push_n,
    input  logic              mode_cont,
    input  logic              sel_sw,
    input  logic [DATA_W-1:0] sw_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    adc_uart_logger_if.master bus
);
    localparam int NDIG = (DATA_W + 3) / 4;
    localparam int SW   = 4 * NDIG;
    localparam int TW   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

    localparam logic [TW-1:0]   TMR_LAST   = TW'(PERIOD_CYC - 1);
    localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);
    // k index of the separator / CR, and k value one past the channel's last char
    localparam logic [2:0]      K_SEP      = 3'(NDIG);
    localparam logic [2:0]      K_END_MID  = 3'(NDIG + 1);
    localparam logic [2:0]      K_END_LAST = 3'(NDIG + 2);

    typedef enum logic [2:0] {IDLE, ADC_REQ, ADC_WAIT, CHAR_LOAD, TX_WAIT, DONE} state_t;

    state_t          r_state, w_state_n;
    logic            r_push_s1, r_push_s2, r_push_s3;
    logic [TW-1:0]   r_tmr;
    logic            r_sel;
    logic [CH_W-1:0] r_ch;
    logic [2:0]      r_k;
    logic [SW-1:0]   r_sample;
    logic            r_adc_start, r_tx_start, r_frame_done, r_busy, r_overrun;
    logic [7:0]      r_tx_data;

    logic            w_trig_btn, w_trig_tmr, w_trig, w_last_ch;
    logic [2:0]      w_k_inc, w_k_end;
    logic            w_go, w_req_adc, w_take, w_load_tx, w_char_adv, w_ch_adv, w_finish;
    logic [7:0]      w_tx_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character k of one channel's text: digits MS nibble first, then ',' or CR, then LF.
    function automatic logic [7:0] frame_char(input logic [SW-1:0] s, input logic [2:0] k,
                                              input logic last);
        logic [SW-1:0] sh;
        logic [7:0]    c;
        sh = '0;
        if (k < K_SEP) begin
            sh = s >> (4 * (NDIG - 1 - int'(k)));
            c  = hex_char(sh[3:0]);
        end else if (k == K_SEP) begin
            c = last ? 8'h0D : 8'h2C;
        end else begin
            c = 8'h0A;
        end
        return c;
    endfunction

    assign w_trig_btn = r_push_s3 & ~r_push_s2;
    assign w_trig_tmr = mode_cont & (r_tmr == TMR_LAST);
    assign w_trig     = w_trig_btn | w_trig_tmr;
    assign w_last_ch  = (r_ch == CH_LAST);
    assign w_k_inc    = r_k + 3'd1;
    assign w_k_end    = w_last_ch ? K_END_LAST : K_END_MID;

    // Button synchronizer (idles released-high) and free-running period timer.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_push_s1 <= 1'b1;
            r_push_s2 <= 1'b1;
            r_push_s3 <= 1'b1;
            r_tmr     <= '0;
        end else begin
            r_push_s1 <= push_n;
            r_push_s2 <= r_push_s1;
            r_push_s3 <= r_push_s2;
            if (!mode_cont || r_tmr == TMR_LAST) r_tmr <= '0;
            else                                 r_tmr <= r_tmr + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= IDLE;
        else        r_state <= w_state_n;
    end

    // Next state and one-cycle action strobes. The first request of a frame is
    // issued straight from IDLE so it appears one cycle after the trigger.
    always_comb begin
        w_state_n  = r_state;
        w_go       = 1'b0;
        w_req_adc  = 1'b0;
        w_take     = 1'b0;
        w_load_tx  = 1'b0;
        w_char_adv = 1'b0;
        w_ch_adv   = 1'b0;
        w_finish   = 1'b0;
        w_tx_byte  = frame_char(r_sample, r_k, w_last_ch);
        case (r_state)
            IDLE: begin
                if (w_trig) begin
                    w_go = 1'b1;
                    if (sel_sw) begin
                        w_load_tx = 1'b1;
                        w_tx_byte = frame_char(SW'(sw_data), 3'd0, 1'b0);
                        w_state_n = TX_WAIT;
                    end else begin
                        w_req_adc = 1'b1;
                        w_state_n = ADC_WAIT;
                    end
                end
            end
            ADC_REQ: begin
                w_req_adc = 1'b1;
                w_state_n = ADC_WAIT;
            end
            ADC_WAIT: begin
                if (bus.adc_done) begin
                    w_take    = 1'b1;
                    w_state_n = CHAR_LOAD;
                end
            end
            CHAR_LOAD: begin
                w_load_tx = 1'b1;
                w_state_n = TX_WAIT;
            end
            TX_WAIT: begin
                if (bus.tx_done) begin
                    if (w_k_inc != w_k_end) begin
                        w_char_adv = 1'b1;
                        w_state_n  = CHAR_LOAD;
                    end else if (!w_last_ch) begin
                        w_ch_adv  = 1'b1;
                        w_state_n = r_sel ? CHAR_LOAD : ADC_REQ;
                    end else begin
                        w_finish  = 1'b1;
                        w_state_n = DONE;
                    end
                end
            end
            DONE:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs driven by the FSM strobes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sel        <= 1'b0;
            r_ch         <= '0;
            r_k          <= '0;
            r_sample     <= '0;
            r_adc_start  <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= '0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_adc_start  <= w_req_adc;
            r_tx_start   <= w_load_tx;
            r_frame_done <= w_finish;
            if (w_load_tx) r_tx_data <= w_tx_byte;
            if (w_go) begin
                r_busy <= 1'b1;
                r_sel  <= sel_sw;
                r_ch   <= '0;
                r_k    <= '0;
                if (sel_sw) r_sample <= SW'(sw_data);
            end
            if (w_take) begin
                r_sample <= SW'(bus.adc_data);
                r_k      <= '0;
            end
            if (w_char_adv) r_k <= w_k_inc;
            if (w_ch_adv) begin
                r_ch <= r_ch + 1'b1;
                r_k  <= '0;
            end
            if (r_state == DONE) r_busy <= 1'b0;
            if (w_trig && r_state != IDLE) r_overrun <= 1'b1;
        end
    end

    assign bus.adc_start = r_adc_start;
    assign bus.adc_ch    = r_ch;
    assign bus.tx_start  = r_tx_start;
    assign bus.tx_data   = r_tx_data;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;
    assign overrun       = r_overrun;
endmodule

// File: tb/tb_adc_uart_logger.sv
// Bench for adc_uart_logger: randomized ADC/UART responders, a frame-level
// text model, and handshake latency / overrun / reset scenarios.
module tb_adc_uart_logger;
    localparam int NUM_CH     = 3;
    localparam int CH_W       = 2;
    localparam int DATA_W     = 10;
    localparam int PERIOD_CYC = 200;
    localparam int NDIG       = (DATA_W + 3) / 4;
    localparam int FRAME_LEN  = NUM_CH * (NDIG + 1) + 1;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              push_n = 1'b1;
    logic              mode_cont = 1'b0;
    logic              sel_sw = 1'b0;
    logic [DATA_W-1:0] sw_data = '0;
    logic              busy, frame_done, overrun;

    adc_uart_logger_if #(.CH_W(CH_W), .DATA_W(DATA_W)) bus ();

    adc_uart_logger #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .PERIOD_CYC(PERIOD_CYC)
    ) dut (
        .clk(clk), .n_rst(n_rst), .push_n(push_n), .mode_cont(mode_cont),
        .sel_sw(sel_sw), .sw_data(sw_data), .busy(busy), .frame_done(frame_done),
        .overrun(overrun), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // responder controls and the sample values actually delivered
    int tx_min = 1, tx_max = 3;
    bit stray_en = 1'b0;
    int adc_q[$];
    int force_q[$];

    // monitor state
    bit         exp_sel = 1'b0;
    int         exp_sw = 0;
    logic [7:0] got[$];
    int         frame_cnt = 0, n_rise = 0, n_bytes_done = 0;
    int         rise_cyc[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ADC master and UART TX models, with optional stray done pulses.
    initial begin
        int  a_cnt, t_cnt, v;
        bit  a_pend, t_pend;
        a_pend = 0; t_pend = 0; a_cnt = 0; t_cnt = 0;
        bus.adc_done = 1'b0; bus.tx_done = 1'b0; bus.adc_data = '0;
        forever begin
            @(posedge clk); #1;
            bus.adc_done = 1'b0;
            bus.tx_done  = 1'b0;
            bus.adc_data = DATA_W'($urandom);
            if (!n_rst) begin
                a_pend = 0; t_pend = 0;
                adc_q.delete();
                continue;
            end
            if (bus.adc_start) begin a_pend = 1; a_cnt = $urandom_range(1, 4); end
            if (bus.tx_start)  begin t_pend = 1; t_cnt = $urandom_range(tx_min, tx_max); end
            if (a_pend) begin
                a_cnt--;
                if (a_cnt == 0) begin
                    v = (force_q.size() > 0) ? force_q.pop_front() : int'($urandom_range(0, 2**DATA_W - 1));
                    bus.adc_data = DATA_W'(v);
                    bus.adc_done = 1'b1;
                    adc_q.push_back(v);
                    a_pend = 0;
                end else if (stray_en && !t_pend && $urandom_range(0, 3) == 0) begin
                    bus.tx_done = 1'b1;
                end
            end
            if (t_pend) begin
                t_cnt--;
                if (t_cnt == 0) begin
                    bus.tx_done = 1'b1;
                    t_pend = 0;
                end else if (stray_en && $urandom_range(0, 3) == 0) begin
                    bus.adc_done = 1'b1;
                end
            end
        end
    end

    // Observer: captures bytes, checks handshake timing and whole frames.
    initial begin
        bit         busy_prev, rose, m_adc_pend, m_tx_pend, chk_fall;
        int         ch_idx, adc_in_frame, last_done;
        logic [7:0] cur, e[$];
        string      hexs;
        int         v;
        hexs = "0123456789ABCDEF";
        busy_prev = 0; m_adc_pend = 0; m_tx_pend = 0; chk_fall = 0;
        ch_idx = 0; adc_in_frame = 0; last_done = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                got.delete();
                busy_prev = 0; m_adc_pend = 0; m_tx_pend = 0; chk_fall = 0;
                continue;
            end
            rose = busy && !busy_prev;
            if (chk_fall) begin chk("busy_fall", busy, 0); chk_fall = 0; end
            if (rose) begin
                ch_idx = 0; adc_in_frame = 0; n_rise++;
                rise_cyc.push_back(cyc);
            end
            if (bus.adc_start) begin
                chk("adc_ch", bus.adc_ch, ch_idx);
                if (!rose) chk("adc_lat", cyc - last_done, 2);
                m_adc_pend = 1; adc_in_frame++; ch_idx++;
            end
            if (bus.tx_start) begin
                got.push_back(bus.tx_data);
                cur = bus.tx_data;
                if (!rose) chk("tx_lat", cyc - last_done, 2);
                m_tx_pend = 1;
            end
            if (bus.adc_done && m_adc_pend) begin last_done = cyc; m_adc_pend = 0; end
            if (bus.tx_done && m_tx_pend) begin
                chk("tx_hold", bus.tx_data, cur);
                last_done = cyc; m_tx_pend = 0; n_bytes_done++;
            end
            if (frame_done) begin
                chk("fd_lat", cyc - last_done, 1);
                chk("fd_busy", busy, 1);
                chk("adc_reqs", adc_in_frame, exp_sel ? 0 : NUM_CH);
                e.delete();
                for (int c = 0; c < NUM_CH; c++) begin
                    if (exp_sel)               v = exp_sw;
                    else if (adc_q.size() > 0) v = adc_q.pop_front();
                    else                       v = 0;
                    for (int d = 0; d < NDIG; d++) e.push_back(hexs[(v >> (4 * (NDIG - 1 - d))) & 15]);
                    if (c < NUM_CH - 1) e.push_back(8'h2C);
                    else begin e.push_back(8'h0D); e.push_back(8'h0A); end
                end
                chk("frame_len", got.size(), FRAME_LEN);
                for (int i = 0; i < e.size(); i++)
                    chk($sformatf("byte%0d", i), (i < got.size()) ? longint'(got[i]) : -1, e[i]);
                got.delete();
                frame_cnt++;
                chk_fall = 1;
            end
            busy_prev = busy;
        end
    end

    task automatic push_and_time();
        int i;
        @(posedge clk); #1 push_n = 1'b0;
        for (i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (bus.adc_start || bus.tx_start) break;
        end
        chk("trig_lat", i, 3);
        repeat (3) @(posedge clk);
        #1 push_n = 1'b1;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_cnt < target && n < budget) begin @(posedge clk); n++; end
        chk("frame_wait", frame_cnt, target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin @(posedge clk); n++; end
        chk("idle_wait", busy, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctl"}, {busy, frame_done, overrun, bus.adc_start, bus.tx_start}, 0);
        chk({tag, "_txd"}, bus.tx_data, 0);
        chk({tag, "_ch"}, bus.adc_ch, 0);
    endtask

    initial begin
        int r0, t0, n, fs, b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_outs("rst");
        @(posedge clk); #3 n_rst = 1'b1;

        // button frames from the ADC, first one with boundary samples
        stray_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            if (f == 0) force_q = '{0, 1023, 165};
            fs = frame_cnt;
            push_and_time();
            wait_frames(fs + 1, 2000);
            chk("ovr_clear", overrun, 0);
            repeat (4) @(posedge clk);
        end

        // switch substitution; later changes to the switches must not leak in
        sw_data = DATA_W'($urandom);
        sel_sw = 1'b1; exp_sel = 1'b1; exp_sw = int'(sw_data);
        fs = frame_cnt;
        push_and_time();
        repeat (15) @(posedge clk);
        #1 sw_data = ~sw_data; sel_sw = 1'b0;
        wait_frames(fs + 1, 2000);
        exp_sel = 1'b0;
        repeat (4) @(posedge clk);

        // periodic triggers with a fast UART
        r0 = n_rise;
        @(posedge clk); #1 mode_cont = 1'b1; t0 = cyc;
        n = 0;
        while (n_rise < r0 + 4 && n < 6 * PERIOD_CYC) begin @(posedge clk); n++; end
        chk("cont_frames", n_rise - r0 >= 4, 1);
        if (rise_cyc.size() >= r0 + 4) begin
            chk("tmr_first", rise_cyc[r0] - t0, PERIOD_CYC);
            for (int i = 0; i < 3; i++) chk("tmr_period", rise_cyc[r0 + i + 1] - rise_cyc[r0 + i], PERIOD_CYC);
        end
        #1 mode_cont = 1'b0;
        wait_idle(2000);
        n = n_rise;
        repeat (3 * PERIOD_CYC) @(posedge clk);
        chk("cont_stop", n_rise, n);
        chk("cont_all_done", frame_cnt, n_rise);
        chk("cont_ovr", overrun, 0);

        // slow UART: second periodic tick lands mid-frame
        tx_min = 20; tx_max = 25;
        r0 = n_rise;
        @(posedge clk); #1 mode_cont = 1'b1;
        n = 0;
        while (!overrun && n < 4 * PERIOD_CYC) begin @(posedge clk); #1; n++; end
        chk("ovr_set", overrun, 1);
        chk("ovr_busy", busy, 1);
        chk("ovr_one_frame", n_rise - r0, 1);
        mode_cont = 1'b0;
        wait_idle(3000);
        chk("ovr_frame_done", frame_cnt, n_rise);
        repeat (5) @(posedge clk);
        chk("ovr_sticky", overrun, 1);
        tx_min = 1; tx_max = 3;

        // reset in the middle of a frame
        b0 = n_bytes_done;
        push_and_time();
        n = 0;
        while (n_bytes_done < b0 + 3 && n < 500) begin @(posedge clk); n++; end
        chk("mid_bytes", n_bytes_done >= b0 + 3, 1);
        @(posedge clk); #3 n_rst = 1'b0;
        #1 chk_reset_outs("arst");
        repeat (2) @(posedge clk);
        #1 chk_reset_outs("arst_hold");
        #2 n_rst = 1'b1;
        n = n_rise;
        repeat (20) @(posedge clk);
        chk("post_rst_quiet", n_rise, n);
        fs = frame_cnt;
        push_and_time();
        wait_frames(fs + 1, 2000);
        chk("post_rst_ovr", overrun, 0);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end
endmodule

// File: doc/adc_uart_logger.md
Name: adc_uart_logger

Overview:
Multi-channel sequencer that sits between a push button or periodic timer, the SPI ADC master and the UART transmitter. On each trigger it samples NUM_CH ADC channels in order, or substitutes the switch value. It converts each sample to uppercase ASCII hex and streams one text frame, with comma separators and CR/LF termination, through the UART TX handshake. It supersedes a fixed single-byte ADC→ASCII→UART chain: it adds channel count, sample width, continuous mode and framing.

Parameters:
NUM_CH, 4, number of channels per frame (1..2**CH_W)
CH_W, 2, width of adc_ch
DATA_W, 8, sample width in bits (4..16); hex digits per sample NDIG = ceil(DATA_W/4)
PERIOD_CYC, 50_000_000, clock cycles between automatic triggers in continuous mode (≥2)

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
push_n  in  1  raw start button, active-low, asynchronous to clk
mode_cont  in  1  1 = periodic triggers every PERIOD_CYC cycles; 0 = button only
sel_sw  in  1  1 = send sw_data in place of every ADC sample
sw_data  in  DATA_W  switch value
adc_start  out  1  one-cycle request to SPI ADC master
adc_ch  out  CH_W  channel for current request; stable from adc_start to adc_done
adc_done  in  1  one-cycle completion from ADC master
adc_data  in  DATA_W  sample, valid in the cycle adc_done=1
tx_start  out  1  one-cycle request to UART TX
tx_data  out  8  ASCII byte; stable from tx_start until tx_done
tx_done  in  1  one-cycle byte-sent from UART TX
busy  out  1  high from trigger until frame complete
frame_done  out  1  one-cycle pulse after last byte's tx_done
overrun  out  1  sticky: a trigger arrived while busy

Behaviour:
- Reset, async and active-low: all outputs 0 (tx_data=8'h00, adc_ch=0). FSM goes to IDLE, timer=0, synchronizers=1 (released). Reset mid-frame aborts it immediately; no further pulses are issued.
- push_n passes through a 2-flop synchronizer. A falling edge of the synchronized signal gives one-cycle trig_btn.
- Timer is held at 0 while mode_cont=0. With mode_cont=1 it counts 0..PERIOD_CYC-1 and wraps. trig_tmr=1 in the wrap cycle.
- trig = trig_btn | trig_tmr. A trig in IDLE starts a frame. A trig while busy is dropped and sets overrun, which clears only on reset.
- At frame start, latch sel_sw into sel_l and sw_data into sw_l. Mid-frame changes to sel_sw or sw_data have no effect. Set ch=0 and busy=1.
- FSM states: IDLE, ADC_REQ, ADC_WAIT, CHAR_LOAD, TX_WAIT, DONE.
  - IDLE→ADC_REQ on trig. If sel_l=1, go to CHAR_LOAD with sample=sw_l instead.
  - ADC_REQ: adc_start=1 for one cycle with adc_ch=ch → ADC_WAIT.
  - ADC_WAIT: on adc_done, sample<=adc_data and char index k=0 → CHAR_LOAD.
  - CHAR_LOAD: tx_data<=char(k), tx_start=1 for one cycle → TX_WAIT.
  - TX_WAIT: on tx_done, k++.
    - If k<NDIG+1 (or +2 for last ch), go to CHAR_LOAD.
    - Otherwise, if ch<NUM_CH-1: ch++ and go to ADC_REQ (CHAR_LOAD when sel_l=1).
    - Otherwise go to DONE.
  - DONE: frame_done=1 for one cycle, busy<=0 → IDLE.
- Characters per channel: NDIG hex digits, MS nibble first, uppercase. Values 0..9→0x30..0x39 and A..F→0x41..0x46. Sample is zero-extended to 4*NDIG bits.
  - Non-last channel: digits followed by ',' (0x2C).
  - Last channel: digits followed by 0x0D, 0x0A.
- Frame length = NUM_CH*(NDIG+1)+1 bytes.
- Timing (registered outputs):
  - trig at cycle t → first adc_start (or tx_start if sel_l) at t+1.
  - adc_done at t → tx_start at t+2.
  - tx_done at t → next tx_start or adc_start at t+2.
  - Last tx_done at t → frame_done at t+1, busy=0 at t+2.
- adc_done outside ADC_WAIT and tx_done outside TX_WAIT are ignored.
- adc_done and tx_done are never required to be simultaneous; if both occur, only the one matching the state is used.
- Trig coinciding with frame_done: FSM is not yet in IDLE, so the trig is dropped and overrun is set.

Test Plan:
- NUM_CH=2, DATA_W=8, sel_sw=0, push once; model returns 0x3A (ch0) and 0xF0 (ch1) → adc_ch sequence 0,1; bytes "3A,F0\r\n" (33 41 2C 46 30 0D 0A); one frame_done; overrun=0.
- sel_sw=1, sw_data=0x05, NUM_CH=2, push → no adc_start; bytes "05,05\r\n"; sw_data changed to 0xFF mid-frame does not alter output.
- mode_cont=1, PERIOD_CYC=2000, fast UART model → frames start exactly 2000 cycles apart; mode_cont=0 → no further frames.
- mode_cont=1, PERIOD_CYC=50, slow UART model → overrun rises on first dropped tick; current frame bytes are unaffected.
- DATA_W=12, NUM_CH=1, sample 0xABC → "ABC\r\n"; tx_data stable for entire tx_start→tx_done window; stray tx_done in ADC_WAIT ignored.
- Assert n_rst low after 3rd byte → all outputs 0 within the reset cycle; after release a new push yields a complete, correct frame.
